// File: rtl/rv32_pipe_pkg.sv
// Shared definitions for the RV32 pipeline slice.
//   XLEN / TYPE_W          : datapath and instruction-class widths
//   CLS_*                  : instruction-class codes. Bits [2:0] != 0 means the
//                            class has no rs2 operand. Bits [4:3] != 0 means the
//                            class writes no rd.
//   has_rs2() / has_rd()   : decode those two properties from a class code
//   de_payload_t           : everything the D->E register carries for one instruction
package rv32_pipe_pkg;

    localparam int XLEN   = 32;
    localparam int TYPE_W = 5;
    localparam int REG_W  = 5;

    typedef logic [TYPE_W-1:0] iclass_t;

    localparam iclass_t CLS_R      = 5'b00000;  // reg-reg ALU: rs1, rs2, rd
    localparam iclass_t CLS_I      = 5'b00001;  // reg-imm ALU: rs1, rd
    localparam iclass_t CLS_LOAD   = 5'b00010;  // load: rs1, rd
    localparam iclass_t CLS_STORE  = 5'b01000;  // store: rs1, rs2
    localparam iclass_t CLS_BRANCH = 5'b10000;  // branch: rs1, rs2

    function automatic logic has_rs2(input iclass_t cls);
        return (cls[2:0] == 3'b000);
    endfunction

    function automatic logic has_rd(input iclass_t cls);
        return (cls[4:3] == 2'b00);
    endfunction

    typedef struct packed {
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [XLEN-1:0]  rdata1;
        logic [XLEN-1:0]  rdata2;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
        iclass_t          cls;
        logic             load;
    } de_payload_t;

endpackage

// File: rtl/fwd_operand_latch.sv
// Resolves one execute-stage source operand and holds it while E is stalled.
//   clk, rst_n : clock, asynchronous active-low reset
//   fresh      : 1 in the first cycle an instruction occupies E
//   idx        : architectural source register index (x0 reads as zero)
//   fwd        : forwarded value from the hazard unit, meaningful when fresh
//   fwd_valid  : forward overrides the register-file data
//   rdata_r    : register-file data captured on the D->E load
//   val        : resolved operand presented to the ALU
// Forwards are only trusted in the fresh cycle; afterwards the value
// resolved then is replayed from the hold register, so forward inputs that
// change while E is held cannot corrupt the operand.
module fwd_operand_latch
    import rv32_pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fresh,
    input  logic [REG_W-1:0] idx,
    input  logic [XLEN-1:0]  fwd,
    input  logic             fwd_valid,
    input  logic [XLEN-1:0]  rdata_r,
    output logic [XLEN-1:0]  val
);

    logic [XLEN-1:0] res;
    logic [XLEN-1:0] hold_q;

    // NOTE: combinational blocks assign a default first so every path
    // drives res and no latch is inferred.
    always_comb begin
        res = '0;
        if (idx != '0) begin
            res = fwd_valid ? fwd : rdata_r;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, and the hold
    // register is reset too so the operand output reads 0 before the first load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (fresh) begin
            hold_q <= res;
        end
    end

    assign val = fresh ? res : hold_q;

endmodule

// File: rtl/de_operand_stage.sv
// Decode-to-execute pipeline register with execute-stage operand resolution.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   flush_E                         : kill E and drop D's offer (redirect)
//   valid_D / ready_D               : D-side handshake
//   pc_D, imm_D, rs1_D, rs2_D, rd_D : decoded instruction payload
//   type_D, load_D                  : instruction class, load flag
//   rdata1_D, rdata2_D              : register-file read data
//   stall_D                         : hazard unit holds D this cycle
//   fwd_rs1/2, fwd_rs1/2_valid      : registered forwards for the instruction in E
//   ready_M                         : downstream accepts E's instruction
//   valid_E, ready_E                : E occupancy and load-enable (to hazard unit)
//   pc_E, imm_E, rd_E, type_E, load_E : registered payload
//   rs1_val_E, rs2_val_E            : resolved operands for the ALU
module de_operand_stage
    import rv32_pipe_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_E,
    input  logic              valid_D,
    output logic              ready_D,
    input  logic [XLEN-1:0]   pc_D,
    input  logic [XLEN-1:0]   imm_D,
    input  logic [REG_W-1:0]  rs1_D,
    input  logic [REG_W-1:0]  rs2_D,
    input  logic [REG_W-1:0]  rd_D,
    input  logic [TYPE_W-1:0] type_D,
    input  logic              load_D,
    input  logic [XLEN-1:0]   rdata1_D,
    input  logic [XLEN-1:0]   rdata2_D,
    input  logic              stall_D,
    input  logic [XLEN-1:0]   fwd_rs1,
    input  logic [XLEN-1:0]   fwd_rs2,
    input  logic              fwd_rs1_valid,
    input  logic              fwd_rs2_valid,
    input  logic              ready_M,
    output logic              valid_E,
    output logic              ready_E,
    output logic [XLEN-1:0]   pc_E,
    output logic [XLEN-1:0]   imm_E,
    output logic [REG_W-1:0]  rd_E,
    output logic [TYPE_W-1:0] type_E,
    output logic              load_E,
    output logic [XLEN-1:0]   rs1_val_E,
    output logic [XLEN-1:0]   rs2_val_E
);

    logic            valid_q;
    logic            fresh_q;
    de_payload_t     pay_q;
    logic            ld;
    logic            live_ld;
    logic [XLEN-1:0] rs2_res;

    assign ready_E = ~valid_q | ready_M;
    // A flush consumes D's offer even when D is stalled, so it is discarded.
    assign ready_D = ready_E & (~stall_D | flush_E);
    assign ld      = ready_E;
    assign live_ld = ld & valid_D & ~stall_D & ~flush_E;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            fresh_q <= 1'b0;
            pay_q   <= '0;
        end else begin
            if (flush_E) begin
                valid_q <= 1'b0;
            end else if (ld) begin
                valid_q <= live_ld;
            end

            // Only a live load starts a fresh cycle; hold, bubble and flush clear it.
            fresh_q <= live_ld;

            if (live_ld) begin
                pay_q <= '{pc: pc_D, imm: imm_D, rdata1: rdata1_D, rdata2: rdata2_D,
                           rs1: rs1_D, rs2: rs2_D, rd: rd_D, cls: type_D, load: load_D};
            end else if (ld || flush_E) begin
                // Bubble: zero the fields the hazard unit inspects so an empty
                // E never reports a false dependency.
                pay_q.rd   <= '0;
                pay_q.cls  <= '0;
                pay_q.load <= 1'b0;
            end
        end
    end

    fwd_operand_latch u_rs1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .fresh     (fresh_q),
        .idx       (pay_q.rs1),
        .fwd       (fwd_rs1),
        .fwd_valid (fwd_rs1_valid),
        .rdata_r   (pay_q.rdata1),
        .val       (rs1_val_E)
    );

    fwd_operand_latch u_rs2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .fresh     (fresh_q),
        .idx       (pay_q.rs2),
        .fwd       (fwd_rs2),
        .fwd_valid (fwd_rs2_valid),
        .rdata_r   (pay_q.rdata2),
        .val       (rs2_res)
    );

    assign valid_E   = valid_q;
    assign pc_E      = pay_q.pc;
    assign imm_E     = pay_q.imm;
    assign rd_E      = pay_q.rd;
    assign type_E    = pay_q.cls;
    assign load_E    = pay_q.load;
    assign rs2_val_E = has_rs2(pay_q.cls) ? rs2_res : '0;

endmodule

// File: tb/tb_de_operand_stage.sv
// Self-checking bench for de_operand_stage. Expected E-stage outputs are
// computed by a small model when an instruction is offered to D, queued,
// and compared when the instruction is visible in E.
module tb_de_operand_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [4:0]  cls;
        logic        load;
        logic [31:0] rd1;
        logic [31:0] rd2;
    } instr_t;

    typedef struct packed {
        logic        f1v;
        logic [31:0] f1;
        logic        f2v;
        logic [31:0] f2;
    } fwd_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  cls;
        logic        load;
        logic [31:0] rs1;
        logic [31:0] rs2;
    } out_t;

    localparam fwd_t NOFWD = '0;

    logic        clk;
    logic        rst_n;
    logic        flush_E;
    logic        valid_D;
    logic        ready_D;
    logic [31:0] pc_D, imm_D, rdata1_D, rdata2_D;
    logic [4:0]  rs1_D, rs2_D, rd_D;
    logic [4:0]  type_D;
    logic        load_D;
    logic        stall_D;
    logic [31:0] fwd_rs1, fwd_rs2;
    logic        fwd_rs1_valid, fwd_rs2_valid;
    logic        ready_M;
    logic        valid_E;
    logic        ready_E;
    logic [31:0] pc_E, imm_E, rs1_val_E, rs2_val_E;
    logic [4:0]  rd_E;
    logic [4:0]  type_E;
    logic        load_E;

    out_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    de_operand_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_E       (flush_E),
        .valid_D       (valid_D),
        .ready_D       (ready_D),
        .pc_D          (pc_D),
        .imm_D         (imm_D),
        .rs1_D         (rs1_D),
        .rs2_D         (rs2_D),
        .rd_D          (rd_D),
        .type_D        (type_D),
        .load_D        (load_D),
        .rdata1_D      (rdata1_D),
        .rdata2_D      (rdata2_D),
        .stall_D       (stall_D),
        .fwd_rs1       (fwd_rs1),
        .fwd_rs2       (fwd_rs2),
        .fwd_rs1_valid (fwd_rs1_valid),
        .fwd_rs2_valid (fwd_rs2_valid),
        .ready_M       (ready_M),
        .valid_E       (valid_E),
        .ready_E       (ready_E),
        .pc_E          (pc_E),
        .imm_E         (imm_E),
        .rd_E          (rd_E),
        .type_E        (type_E),
        .load_E        (load_E),
        .rs1_val_E     (rs1_val_E),
        .rs2_val_E     (rs2_val_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: x0 reads zero, a valid forward beats register data, and a
    // class without rs2 presents zero on the second operand.
    function automatic out_t model(instr_t i, fwd_t f);
        out_t o;
        o.valid = 1'b1;
        o.pc    = i.pc;
        o.imm   = i.imm;
        o.rd    = i.rd;
        o.cls   = i.cls;
        o.load  = i.load;
        o.rs1   = (i.rs1 == 5'd0) ? 32'd0 : (f.f1v ? f.f1 : i.rd1);
        if (i.cls[2:0] != 3'b000 || i.rs2 == 5'd0) o.rs2 = 32'd0;
        else o.rs2 = f.f2v ? f.f2 : i.rd2;
        return o;
    endfunction

    function automatic out_t observed();
        return {valid_E, pc_E, imm_E, rd_E, type_E, load_E, rs1_val_E, rs2_val_E};
    endfunction

    function automatic out_t pop_exp();
        if (sb_q.size() == 0) return 'x;
        return sb_q.pop_front();
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_d(input instr_t i);
        valid_D  = 1'b1;
        pc_D     = i.pc;
        imm_D    = i.imm;
        rs1_D    = i.rs1;
        rs2_D    = i.rs2;
        rd_D     = i.rd;
        type_D   = i.cls;
        load_D   = i.load;
        rdata1_D = i.rd1;
        rdata2_D = i.rd2;
    endtask

    task automatic idle_d();
        valid_D = 1'b0;
        stall_D = 1'b0;
        flush_E = 1'b0;
    endtask

    task automatic drive_fwd(input fwd_t f);
        fwd_rs1_valid = f.f1v;
        fwd_rs1       = f.f1;
        fwd_rs2_valid = f.f2v;
        fwd_rs2       = f.f2;
    endtask

    task automatic test_reset();
        out_t o;
        o = observed();
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h expected 0", o);
        end
        n_cmp++;
        if (ready_E !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready_E: got %b expected 1", ready_E);
        end
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_no_hazard();
        instr_t a;
        out_t   o, e;
        a = '{pc: 32'h100, imm: 32'h0, rs1: 5'd1, rs2: 5'd2, rd: 5'd3, cls: 5'b00000,
              load: 1'b0, rd1: 32'd5, rd2: 32'd7};
        cyc();
        drive_d(a);
        drive_fwd(NOFWD);
        ready_M = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ready_D !== 1'b1) begin
            n_bad++;
            $display("FAIL nohaz_ready_D: got %b expected 1", ready_D);
        end
        sb_q.push_back(model(a, NOFWD));
        cyc();
        idle_d();
        @(negedge clk);
        o = observed();
        e = pop_exp();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL nohaz_add: got %h expected %h", o, e);
        end
        cyc();
        @(negedge clk);
        n_cmp++;
        if (valid_E !== 1'b0 || rd_E !== 5'd0) begin
            n_bad++;
            $display("FAIL nohaz_drain: got valid_E=%b rd_E=%0d expected 0/0", valid_E, rd_E);
        end
    endtask

    task automatic test_forward();
        instr_t a, b;
        fwd_t   f;
        out_t   o;
        a = '{pc: 32'h200, imm: 32'h4, rs1: 5'd4, rs2: 5'd5, rd: 5'd6, cls: 5'b00000,
              load: 1'b0, rd1: 32'h100, rd2: 32'h200};
        b = '{pc: 32'h204, imm: 32'h0, rs1: 5'd6, rs2: 5'd6, rd: 5'd10, cls: 5'b00000,
              load: 1'b0, rd1: 32'h1, rd2: 32'h2};
        f = '{f1v: 1'b1, f1: 32'h11, f2v: 1'b0, f2: 32'h0};
        cyc();
        drive_d(a);
        ready_M = 1'b1;
        @(negedge clk);
        sb_q.push_back(model(a, f));
        cyc();
        drive_d(b);
        drive_fwd(f);
        ready_M = 1'b0;
        @(negedge clk);
        o = observed();
        n_cmp++;
        if (o !== sb_q[0]) begin
            n_bad++;
            $display("FAIL fwd_fresh: got %h expected %h", o, sb_q[0]);
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            fwd_rs1       = 32'h22;
            fwd_rs2_valid = 1'b1;
            fwd_rs2       = 32'h33;
            @(negedge clk);
            o = observed();
            n_cmp++;
            if (o !== sb_q[0]) begin
                n_bad++;
                $display("FAIL fwd_hold%0d: got %h expected %h", k, o, sb_q[0]);
            end
            n_cmp++;
            if (ready_D !== 1'b0 || ready_E !== 1'b0) begin
                n_bad++;
                $display("FAIL fwd_hold_ready%0d: got ready_D=%b ready_E=%b expected 0/0",
                         k, ready_D, ready_E);
            end
        end
        cyc();
        valid_D = 1'b0;
        drive_fwd(NOFWD);
        ready_M = 1'b1;
        @(negedge clk);
        o = observed();
        n_cmp++;
        if (o !== sb_q[0]) begin
            n_bad++;
            $display("FAIL fwd_release: got %h expected %h", o, sb_q[0]);
        end
        void'(pop_exp());
        cyc();
        @(negedge clk);
        n_cmp++;
        if (valid_E !== 1'b0) begin
            n_bad++;
            $display("FAIL fwd_after_release: got valid_E=%b expected 0", valid_E);
        end
    endtask

    task automatic test_load_use();
        instr_t l, c;
        fwd_t   fc;
        out_t   o, e;
        l = '{pc: 32'h300, imm: 32'h8, rs1: 5'd2, rs2: 5'd9, rd: 5'd7, cls: 5'b00010,
              load: 1'b1, rd1: 32'h1000, rd2: 32'h5555};
        c = '{pc: 32'h304, imm: 32'h0, rs1: 5'd7, rs2: 5'd1, rd: 5'd8, cls: 5'b00000,
              load: 1'b0, rd1: 32'hDEAD, rd2: 32'h9};
        fc = '{f1v: 1'b1, f1: 32'hABCD, f2v: 1'b0, f2: 32'h0};
        cyc();
        drive_d(l);
        drive_fwd(NOFWD);
        ready_M = 1'b1;
        @(negedge clk);
        sb_q.push_back(model(l, NOFWD));
        cyc();
        drive_d(c);
        stall_D = 1'b1;
        @(negedge clk);
        o = observed();
        e = pop_exp();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL lu_load_in_E: got %h expected %h", o, e);
        end
        n_cmp++;
        if (ready_D !== 1'b0) begin
            n_bad++;
            $display("FAIL lu_stall_ready_D: got %b expected 0", ready_D);
        end
        cyc();
        stall_D = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (valid_E !== 1'b0 || rd_E !== 5'd0 || load_E !== 1'b0 || type_E !== 5'd0) begin
            n_bad++;
            $display("FAIL lu_bubble: got valid_E=%b rd_E=%0d load_E=%b type_E=%0d expected 0/0/0/0",
                     valid_E, rd_E, load_E, type_E);
        end
        n_cmp++;
        if (ready_D !== 1'b1) begin
            n_bad++;
            $display("FAIL lu_release_ready_D: got %b expected 1", ready_D);
        end
        sb_q.push_back(model(c, fc));
        cyc();
        idle_d();
        drive_fwd(fc);
        @(negedge clk);
        o = observed();
        e = pop_exp();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL lu_consumer: got %h expected %h", o, e);
        end
        cyc();
        drive_fwd(NOFWD);
    endtask

    task automatic test_flush();
        instr_t x, y, z;
        out_t   o, e;
        x = '{pc: 32'h400, imm: 32'h1, rs1: 5'd1, rs2: 5'd2, rd: 5'd11, cls: 5'b00000,
              load: 1'b0, rd1: 32'h41, rd2: 32'h42};
        y = '{pc: 32'h404, imm: 32'h2, rs1: 5'd11, rs2: 5'd3, rd: 5'd12, cls: 5'b00000,
              load: 1'b0, rd1: 32'h43, rd2: 32'h44};
        z = '{pc: 32'h500, imm: 32'h3, rs1: 5'd4, rs2: 5'd0, rd: 5'd13, cls: 5'b01000,
              load: 1'b0, rd1: 32'h45, rd2: 32'h46};
        ready_M = 1'b1;
        cyc();
        drive_d(x);
        @(negedge clk);
        sb_q.push_back(model(x, NOFWD));
        cyc();
        drive_d(y);
        stall_D = 1'b1;
        flush_E = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ready_D !== 1'b1) begin
            n_bad++;
            $display("FAIL flush_ready_D: got %b expected 1", ready_D);
        end
        o = observed();
        e = pop_exp();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL flush_victim: got %h expected %h", o, e);
        end
        cyc();
        idle_d();
        @(negedge clk);
        n_cmp++;
        if (valid_E !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_drops: got valid_E=%b expected 0", valid_E);
        end
        // Flush of an instruction that is being held by downstream.
        cyc();
        drive_d(z);
        @(negedge clk);
        sb_q.push_back(model(z, NOFWD));
        cyc();
        idle_d();
        ready_M = 1'b0;
        @(negedge clk);
        o = observed();
        e = pop_exp();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL flush_held_pre: got %h expected %h", o, e);
        end
        cyc();
        flush_E = 1'b1;
        @(negedge clk);
        cyc();
        flush_E = 1'b0;
        ready_M = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (valid_E !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_held_drops: got valid_E=%b expected 0", valid_E);
        end
    endtask

    task automatic test_x0_no_rs2();
        instr_t p, q;
        fwd_t   fp, fq;
        out_t   o, e;
        p  = '{pc: 32'h600, imm: 32'h10, rs1: 5'd0, rs2: 5'd3, rd: 5'd9, cls: 5'b00001,
               load: 1'b0, rd1: 32'h55, rd2: 32'h66};
        q  = '{pc: 32'h604, imm: 32'h0, rs1: 5'd5, rs2: 5'd0, rd: 5'd14, cls: 5'b00000,
               load: 1'b0, rd1: 32'h12, rd2: 32'h34};
        fp = '{f1v: 1'b1, f1: 32'hFF, f2v: 1'b1, f2: 32'h77};
        fq = '{f1v: 1'b0, f1: 32'h88, f2v: 1'b1, f2: 32'h99};
        ready_M = 1'b1;
        cyc();
        drive_d(p);
        @(negedge clk);
        sb_q.push_back(model(p, fp));
        cyc();
        drive_d(q);
        drive_fwd(fp);
        @(negedge clk);
        o = observed();
        e = pop_exp();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL x0_itype: got %h expected %h", o, e);
        end
        sb_q.push_back(model(q, fq));
        cyc();
        idle_d();
        drive_fwd(fq);
        @(negedge clk);
        o = observed();
        e = pop_exp();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL x0_rs2: got %h expected %h", o, e);
        end
        cyc();
        drive_fwd(NOFWD);
    endtask

    task automatic test_back_to_back();
        instr_t      ins[6];
        fwd_t        fw[6];
        logic [4:0]  cls_set[4];
        out_t        o, e;
        cls_set = '{5'b00000, 5'b00001, 5'b00010, 5'b01000};
        for (int k = 0; k < 6; k++) begin
            ins[k].pc   = $urandom;
            ins[k].imm  = $urandom;
            ins[k].rs1  = 5'($urandom_range(0, 31));
            ins[k].rs2  = 5'($urandom_range(0, 31));
            ins[k].rd   = 5'($urandom_range(1, 31));
            ins[k].cls  = cls_set[$urandom_range(0, 3)];
            ins[k].load = (ins[k].cls == 5'b00010);
            ins[k].rd1  = $urandom;
            ins[k].rd2  = $urandom;
            fw[k].f1v   = 1'($urandom_range(0, 1));
            fw[k].f1    = $urandom;
            fw[k].f2v   = 1'($urandom_range(0, 1));
            fw[k].f2    = $urandom;
        end
        ready_M = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            cyc();
            if (k < 6) drive_d(ins[k]);
            else idle_d();
            drive_fwd((k > 0) ? fw[k-1] : NOFWD);
            @(negedge clk);
            if (k > 0) begin
                o = observed();
                e = pop_exp();
                n_cmp++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL b2b_%0d: got %h expected %h", k - 1, o, e);
                end
            end
            if (k < 6) begin
                n_cmp++;
                if (ready_D !== 1'b1) begin
                    n_bad++;
                    $display("FAIL b2b_ready_D_%0d: got %b expected 1", k, ready_D);
                end
                sb_q.push_back(model(ins[k], fw[k]));
            end
        end
        cyc();
        drive_fwd(NOFWD);
    endtask

    task automatic test_async_reset();
        instr_t a, b;
        out_t   o;
        a = '{pc: 32'h700, imm: 32'h7, rs1: 5'd3, rs2: 5'd4, rd: 5'd15, cls: 5'b00000,
              load: 1'b0, rd1: 32'h77, rd2: 32'h78};
        b = '{pc: 32'h704, imm: 32'h8, rs1: 5'd15, rs2: 5'd4, rd: 5'd16, cls: 5'b00000,
              load: 1'b0, rd1: 32'h79, rd2: 32'h7A};
        ready_M = 1'b1;
        cyc();
        drive_d(a);
        cyc();
        drive_d(b);
        #2;
        rst_n = 1'b0;
        #1;
        o = observed();
        n_cmp++;
        if (valid_E !== 1'b0 || rd_E !== 5'd0 || rs1_val_E !== 32'd0) begin
            n_bad++;
            $display("FAIL areset_midop: got valid_E=%b rd_E=%0d rs1_val_E=%h expected 0/0/0",
                     valid_E, rd_E, rs1_val_E);
        end
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("FAIL areset_all: got %h expected 0", o);
        end
        sb_q.delete();
        cyc();
        idle_d();
        rst_n = 1'b1;
        @(negedge clk);
        o = observed();
        n_cmp++;
        if (o !== '0) begin
            n_bad++;
            $display("FAIL areset_after: got %h expected 0", o);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle_d();
        ready_M  = 1'b1;
        pc_D     = '0;
        imm_D    = '0;
        rs1_D    = '0;
        rs2_D    = '0;
        rd_D     = '0;
        type_D   = '0;
        load_D   = 1'b0;
        rdata1_D = '0;
        rdata2_D = '0;
        drive_fwd(NOFWD);
        #2;
        test_reset();
        test_no_hazard();
        test_forward();
        test_load_use();
        test_flush();
        test_x0_no_rs2();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
